// File: rtl/baseerat_mux_pkg.sv
// baseerat_mux_pkg: shared constants, state type and clog2 helper for the baseerat muxes
package baseerat_mux_pkg;
    localparam int SECTION_WIDTH = 16;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR = 1;
    typedef enum logic {IDLE, LOCK} state_e;
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
endpackage

// File: rtl/baseerat_rr_arbiter.sv
// baseerat_rr_arbiter: fixed-priority or round-robin one-hot arbiter with packet lock override
module baseerat_rr_arbiter
    import baseerat_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int SEL_W = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_IN-1:0] req,
    input  logic              lock,
    input  logic [SEL_W-1:0]  lock_idx,
    input  logic              advance,
    output logic [NUM_IN-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d, base, pick_idx;
    logic [NUM_IN-1:0] req_rot;
    logic              found;

    assign base = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;
    assign req_rot = NUM_IN'({req, req} >> base);

    // First requester in the rotated view; offset is mapped back to a source index
    always_comb begin
        found = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                pick_idx = SEL_W'((int'(base) + k) % NUM_IN);
            end
        end
    end

    assign grant_idx = lock ? lock_idx : pick_idx;
    assign grant = (lock || found) ? (NUM_IN'(1) << grant_idx) : '0;

    // Pointer moves past the source whose packet just ended
    always_comb begin
        rr_ptr_d = advance ? ((grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
    end

    // Round-robin pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) rr_ptr_q <= '0;
        else rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/baseerat_arb_mux.sv
// baseerat_arb_mux: packet-aware N:1 stream mux with arbitration and a 2-entry output skid buffer
module baseerat_arb_mux
    import baseerat_mux_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int NUM_IN = 4,
    parameter int ARB_MODE = ARB_RR,
    localparam int SEL_W = (clog2(NUM_IN) < 1) ? 1 : clog2(NUM_IN)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_last,
    output logic [NUM_IN-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    output logic                         out_last,
    output logic [SEL_W-1:0]             out_src,
    input  logic                         out_ready
);
    localparam int NSEC = DATA_WIDTH / SECTION_WIDTH;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        lock_idx_q, lock_idx_d, grant_idx;
    logic [NUM_IN-1:0]       grant;
    logic [1:0]              count_q, count_d;
    logic [DATA_WIDTH-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d, sel_data;
    logic                    head_last_q, head_last_d, tail_last_q, tail_last_d, sel_last;
    logic [SEL_W-1:0]        head_src_q, head_src_d, tail_src_q, tail_src_d;
    logic                    push, pop, advance, load_head, load_tail, shift;

    baseerat_rr_arbiter #(.NUM_IN(NUM_IN), .ARB_MODE(ARB_MODE)) u_arb (
        .clock(clock),
        .reset(reset),
        .req(in_valid),
        .lock(state_q == LOCK),
        .lock_idx(lock_idx_q),
        .advance(advance),
        .grant(grant),
        .grant_idx(grant_idx)
    );

    for (genvar s = 0; s < NSEC; s++) begin : g_sec
        logic [SECTION_WIDTH-1:0] sec;
        // One-hot AND-OR of this section across all sources
        always_comb begin
            sec = '0;
            for (int i = 0; i < NUM_IN; i++)
                sec = sec | ({SECTION_WIDTH{grant[i]}} & in_data[i*DATA_WIDTH + s*SECTION_WIDTH +: SECTION_WIDTH]);
        end
        assign sel_data[s*SECTION_WIDTH +: SECTION_WIDTH] = sec;
    end

    assign sel_last  = |(grant & in_last);
    assign in_ready  = reset ? '0 : (grant & {NUM_IN{count_q != 2'd2}});
    assign push      = |(in_valid & in_ready);
    assign out_valid = count_q != 2'd0;
    assign pop       = out_valid && out_ready;
    assign advance   = push && sel_last;
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign out_src   = head_src_q;

    // Packet lock: a non-last beat pins the grant until that source's last beat is taken
    always_comb begin
        state_d = state_q;
        lock_idx_d = lock_idx_q;
        if (state_q == IDLE && push && !sel_last) begin
            state_d = LOCK;
            lock_idx_d = grant_idx;
        end else if (state_q == LOCK && advance) begin
            state_d = IDLE;
        end
    end

    // Skid buffer: head feeds the output, tail only fills when the head is stalled
    always_comb begin
        load_head = push && (count_q == 2'd0 || (count_q == 2'd1 && pop));
        load_tail = push && count_q == 2'd1 && !pop;
        shift = pop && count_q == 2'd2;
        head_data_d = load_head ? sel_data : shift ? tail_data_q : head_data_q;
        head_last_d = load_head ? sel_last : shift ? tail_last_q : head_last_q;
        head_src_d = load_head ? grant_idx : shift ? tail_src_q : head_src_q;
        tail_data_d = load_tail ? sel_data : tail_data_q;
        tail_last_d = load_tail ? sel_last : tail_last_q;
        tail_src_d = load_tail ? grant_idx : tail_src_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State, lock index and buffer registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_idx_q <= '0;
            count_q <= '0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            head_src_q <= '0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
            tail_src_q <= '0;
        end else begin
            state_q <= state_d;
            lock_idx_q <= lock_idx_d;
            count_q <= count_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            head_src_q <= head_src_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
            tail_src_q <= tail_src_d;
        end
    end
endmodule

// File: tb/tb_baseerat_arb_mux.sv
// tb_baseerat_arb_mux: table vectors, directed corner cases and a queue-model random run
module tb_baseerat_arb_mux;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data, fp_data;
    logic [3:0]   in_valid, in_last, in_ready, fp_valid, fp_last, fp_ready;
    logic [31:0]  out_data, fp_out_data;
    logic         out_valid, out_last, out_ready, fp_out_valid, fp_out_last, fp_out_ready;
    logic [1:0]   out_src, fp_out_src;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] l;
        logic       ordy;
        logic [3:0] rdy;
        logic       ov;
        logic [1:0] src;
        logic       ol;
    } vec_t;
    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [1:0]  s;
    } beat_t;

    vec_t        tbl[13];
    beat_t       mq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_acc, lk, rr, g;
    logic        a;
    logic [31:0] nd, ed;
    logic [3:0]  er, acc;

    always #5 clk = ~clk;

    baseerat_arb_mux #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(1)) u_rr (
        .clock(clk), .reset(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_src(out_src), .out_ready(out_ready)
    );

    baseerat_arb_mux #(.DATA_WIDTH(32), .NUM_IN(4), .ARB_MODE(0)) u_fp (
        .clock(clk), .reset(rst), .in_data(fp_data), .in_valid(fp_valid), .in_last(fp_last),
        .in_ready(fp_ready), .out_data(fp_out_data), .out_valid(fp_out_valid), .out_last(fp_out_last),
        .out_src(fp_out_src), .out_ready(fp_out_ready)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dpat(input int i);
        return 32'hA000_0000 | 32'(i);
    endfunction

    initial begin
        tbl = '{
            '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0},
            '{4'b1110, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b1},
            '{4'b1100, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1},
            '{4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b1},
            '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b1},
            '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0},
            '{4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0},
            '{4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b1},
            '{4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0},
            '{4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0},
            '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b1},
            '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b1},
            '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0}
        };
        rst = 1'b1;
        in_valid = 4'hF;
        in_last = 4'hF;
        in_data = {dpat(3), dpat(2), dpat(1), dpat(0)};
        out_ready = 1'b1;
        fp_valid = 4'hF;
        fp_last = 4'hF;
        fp_data = {dpat(3), dpat(2), dpat(1), dpat(0)};
        fp_out_ready = 1'b1;
        #12;
        chk("reset in_ready", in_ready, 0);
        chk("reset fp in_ready", fp_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset out_src", out_src, 0);
        chk("reset out_data", out_data, 0);
        in_valid = 4'h0;
        fp_valid = 4'h0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            in_valid = tbl[i].v;
            in_last = tbl[i].l;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d in_ready", i), in_ready, tbl[i].rdy);
            chk($sformatf("vec%0d out_valid", i), out_valid, tbl[i].ov);
            if (tbl[i].ov) begin
                chk($sformatf("vec%0d out_src", i), out_src, tbl[i].src);
                chk($sformatf("vec%0d out_last", i), out_last, tbl[i].ol);
                chk($sformatf("vec%0d out_data", i), out_data, dpat(int'(tbl[i].src)));
            end
        end

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 4'b0001;
        in_last = 4'b0001;
        nd = 32'h5000_0000;
        in_data[31:0] = nd;
        n_acc = 0;
        repeat (4) begin
            @(negedge clk);
            a = in_ready[0];
            n_acc += int'(a);
            @(posedge clk);
            #1;
            if (a) begin
                nd++;
                in_data[31:0] = nd;
            end
        end
        chk("bp accepted beats", n_acc, 2);
        @(negedge clk);
        chk("bp in_ready low when full", in_ready, 0);
        out_ready = 1'b1;
        ed = 32'h5000_0000;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("bp drain%0d out_valid", k), out_valid, 1);
            chk($sformatf("bp drain%0d out_data", k), out_data, ed);
            ed++;
            a = in_ready[0];
            @(posedge clk);
            #1;
            if (a) begin
                nd++;
                in_data[31:0] = nd;
            end
            @(negedge clk);
        end
        in_valid = 4'h0;
        repeat (3) @(negedge clk);

        fp_valid = 4'b1010;
        fp_last = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("fixed%0d in_ready", k), fp_ready, 4'b0010);
            chk($sformatf("fixed%0d out_valid", k), fp_out_valid, k > 0);
            if (k > 0) begin
                chk($sformatf("fixed%0d out_src", k), fp_out_src, 1);
                chk($sformatf("fixed%0d out_data", k), fp_out_data, dpat(1));
            end
            @(negedge clk);
        end
        fp_valid = 4'h0;

        out_ready = 1'b0;
        in_valid = 4'b0010;
        in_last = 4'b0000;
        in_data = {dpat(3), dpat(2), dpat(1), dpat(0)};
        repeat (3) @(negedge clk);
        chk("mid-packet full in_ready", in_ready, 0);
        chk("mid-packet full out_valid", out_valid, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 4'b0011;
        in_last = 4'b0011;
        #1;
        chk("post-reset grant from 0", in_ready, 4'b0001);
        in_valid = 4'h0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mq.delete();
        lk = -1;
        rr = 0;
        acc = 4'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (!in_valid[i] || acc[i]) begin
                    in_valid[i] = $urandom_range(0, 2) != 0;
                    in_last[i] = $urandom_range(0, 2) == 0;
                    in_data[i*32 +: 32] = $urandom;
                end
            end
            out_ready = $urandom_range(0, 3) != 0;
            @(negedge clk);
            g = lk;
            for (int k = 0; k < 4; k++)
                if (g < 0 && in_valid[(rr + k) % 4]) g = (rr + k) % 4;
            er = (g >= 0 && mq.size() < 2) ? 4'(1 << g) : 4'h0;
            chk("rnd in_ready", in_ready, er);
            chk("rnd out_valid", out_valid, mq.size() != 0);
            if (mq.size() != 0) chk("rnd head beat", {out_data, out_last, out_src}, mq[0]);
            acc = in_valid & er;
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (acc != 4'h0) begin
                mq.push_back(beat_t'({in_data[g*32 +: 32], in_last[g], 2'(g)}));
                if (in_last[g]) begin
                    lk = -1;
                    rr = (g + 1) % 4;
                end else begin
                    lk = g;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
